// File: rtl/adc_linetrain.sv
// adc_linetrain: automatic per-line IODELAY/bitslip training sequencer for the ADC receive path
//
// Trains NLINES deserialised lines of SER bits one after another until each returns a
// stable word equal to its expected pattern. It first tries bitslips, then delay taps.
// Ports:
//   CLK     data clock (divided ADC clock)
//   RSTn    asynchronous active-low reset
//   START   level input; a rising edge in idle/done starts a training run
//   DATA    deserialised words, line k = DATA[SER*k +: SER]
//   PAT     expected word per line, same slicing as DATA
//   DRST    one-cycle IODELAY reset for all lines
//   DINC    one-cycle, one-hot IODELAY increment
//   BS      one-cycle, one-hot ISERDES bitslip
//   BUSY    training in progress
//   DONE    training finished; held until the next START edge
//   LOCKED  line k locked to PAT
//   FAILED  line k exhausted MAXTAP increments
//   TAPS    8-bit tap count of line k at lock or fail
module adc_linetrain #(
    parameter int NLINES    = 9,
    parameter int SER       = 6,
    parameter int NCHK      = 16,
    parameter int SLIP_WAIT = 4,
    parameter int INC_WAIT  = 4,
    parameter int MAXTAP    = 64
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 START,
    input  logic [NLINES*SER-1:0] DATA,
    input  logic [NLINES*SER-1:0] PAT,
    output logic                 DRST,
    output logic [NLINES-1:0]    DINC,
    output logic [NLINES-1:0]    BS,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [NLINES-1:0]    LOCKED,
    output logic [NLINES-1:0]    FAILED,
    output logic [NLINES*8-1:0]  TAPS
);
    localparam int MW = (NCHK > SLIP_WAIT) ? ((NCHK > INC_WAIT) ? NCHK : INC_WAIT)
                                           : ((SLIP_WAIT > INC_WAIT) ? SLIP_WAIT : INC_WAIT);
    localparam int CW = $clog2(MW + 1);
    localparam int LW = (NLINES > 1) ? $clog2(NLINES) : 1;
    localparam int SW = (SER > 1) ? $clog2(SER) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RST, S_WAIT, S_CHECK, S_SLIP, S_INC, S_NEXT, S_FIN} state_t;

    state_t          state, nxt;
    logic [CW-1:0]   cnt;
    logic [LW-1:0]   ln;
    logic [7:0]      tap;
    logic [SW-1:0]   slips;
    logic [SER-1:0]  ref_w;
    logic            unstable;
    logic            start_q;
    logic [SER-1:0]  word, want;
    logic [NLINES-1:0] sel;
    logic            start_edge, last_chk, stable, match, last_line, tap_max, slip_ok;

    assign word       = DATA[int'(ln)*SER +: SER];
    assign want       = PAT[int'(ln)*SER +: SER];
    assign sel        = NLINES'(1) << ln;
    assign start_edge = START & ~start_q;
    assign last_chk   = cnt == CW'(NCHK - 1);
    // the last check word is folded in directly so the decision needs no extra cycle
    assign stable     = ~unstable & (word == ref_w);
    assign match      = ref_w == want;
    assign last_line  = ln == LW'(NLINES - 1);
    assign tap_max    = tap == 8'(MAXTAP);
    assign slip_ok    = slips != SW'(SER - 1);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_FIN: nxt = start_edge ? S_RST : state;
            S_RST:         nxt = S_WAIT;
            S_WAIT:        nxt = (cnt == '0) ? S_CHECK : S_WAIT;
            S_CHECK:       nxt = !last_chk ? S_CHECK :
                                 (stable && match) ? S_NEXT :
                                 (stable && slip_ok) ? S_SLIP : S_INC;
            S_SLIP:        nxt = S_WAIT;
            S_INC:         nxt = tap_max ? S_NEXT : S_WAIT;
            S_NEXT:        nxt = last_line ? S_FIN : S_CHECK;
            default:       nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= S_IDLE;
            // starts high so a START already high at reset release is not an edge
            start_q  <= 1'b1;
            cnt      <= '0;
            ln       <= '0;
            tap      <= '0;
            slips    <= '0;
            ref_w    <= '0;
            unstable <= 1'b0;
            DRST     <= 1'b0;
            DINC     <= '0;
            BS       <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            LOCKED   <= '0;
            FAILED   <= '0;
            TAPS     <= '0;
        end else begin
            state   <= nxt;
            start_q <= START;
            DRST    <= nxt == S_RST;
            DINC    <= (nxt == S_INC && !tap_max) ? sel : '0;
            BS      <= (nxt == S_SLIP) ? sel : '0;
            BUSY    <= !(nxt == S_IDLE || nxt == S_FIN);
            DONE    <= nxt == S_FIN;
            case (state)
                S_IDLE, S_FIN: begin
                    if (start_edge) begin
                        LOCKED <= '0;
                        FAILED <= '0;
                        TAPS   <= '0;
                        ln     <= '0;
                        tap    <= '0;
                        slips  <= '0;
                    end
                end
                S_RST:  cnt <= CW'(INC_WAIT - 1);
                S_WAIT: cnt <= (cnt == '0) ? cnt : cnt - CW'(1);
                S_CHECK: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == '0) begin
                        ref_w    <= word;
                        unstable <= 1'b0;
                    end else if (word != ref_w) begin
                        unstable <= 1'b1;
                    end
                    if (last_chk && stable && match) begin
                        LOCKED[ln]            <= 1'b1;
                        TAPS[int'(ln)*8 +: 8] <= tap;
                    end
                end
                S_SLIP: begin
                    slips <= slips + SW'(1);
                    cnt   <= CW'(SLIP_WAIT - 1);
                end
                S_INC: begin
                    if (tap_max) begin
                        FAILED[ln]            <= 1'b1;
                        TAPS[int'(ln)*8 +: 8] <= tap;
                    end else begin
                        tap   <= tap + 8'd1;
                        slips <= '0;
                        cnt   <= CW'(INC_WAIT - 1);
                    end
                end
                S_NEXT: begin
                    cnt <= '0;
                    if (!last_line) begin
                        ln    <= ln + LW'(1);
                        tap   <= '0;
                        slips <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
